multicycle_ctrl: RTL

//  Moore FSM sequencing the multi-cycle RV32I datapath: fetch, decode, execute, memory, writeback.

---
 rtl/multicycle_ctrl_if.sv | 31 +++
 rtl/multicycle_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/status bundle between the RV32I sequencer and its datapath/memory
interface multicycle_ctrl_if;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        adr_src;
   logic        ir_write;
   logic        pc_write;
   logic        reg_write;
   logic [1:0]  imm_src;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic [1:0]  result_src;
   logic        retire;
   logic        illegal;

   modport master (
      input  instr, zero, mem_ready,
      output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
             imm_src, alu_src_a, alu_src_b, alu_op, result_src, retire, illegal
   );

   modport slave (
      output instr, zero, mem_ready,
      input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
             imm_src, alu_src_a, alu_src_b, alu_op, result_src, retire, illegal
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore sequencer for the multi-cycle RV32I datapath with memory timeout trap
module multicycle_ctrl #(
   parameter int TIMEOUT = 16
) (
   input logic              clk,
   input logic              rst_n,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXEC_R, EXEC_I, ALUWB, BRANCH, TRAP
   } state_t;

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_t        state, nxt;
   logic [CW-1:0] cnt;
   logic          timeout_hit;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic          is_store;

   logic          req_q, we_q, adr_q, rw_q, ret_q, ill_q;
   logic          fetch_q, memwr_q, beq_q, bne_q;
   logic [1:0]    imm_q, a_q, b_q, op_q, rs_q;

   logic          unused_instr;
   assign unused_instr = ^{bus.instr[31:15], bus.instr[11:7]};

   assign opcode   = bus.instr[6:0];
   assign funct3   = bus.instr[14:12];
   assign is_store = (opcode == 7'b0100011);

   // the counter value seen here is the number of stalled cycles before this one
   assign timeout_hit = (TIMEOUT != 0) && req_q && !bus.mem_ready &&
                        (cnt == CW'(TIMEOUT - 1));

   always_comb begin
      nxt = state;
      case (state)
         IDLE:   nxt = FETCH;
         FETCH:  if (bus.mem_ready) nxt = DECODE;
                 else if (timeout_hit) nxt = TRAP;
         DECODE: begin
            case (opcode)
               7'b0000011, 7'b0100011: nxt = MEMADR;
               7'b0110011:             nxt = EXEC_R;
               7'b0010011:             nxt = EXEC_I;
               7'b1100011:             nxt = (funct3 == 3'b000 || funct3 == 3'b001) ? BRANCH : TRAP;
               default:                nxt = TRAP;
            endcase
         end
         MEMADR: nxt = is_store ? MEMWR : MEMRD;
         MEMRD:  if (bus.mem_ready) nxt = MEMWB;
                 else if (timeout_hit) nxt = TRAP;
         MEMWB:  nxt = FETCH;
         MEMWR:  if (bus.mem_ready) nxt = FETCH;
                 else if (timeout_hit) nxt = TRAP;
         EXEC_R, EXEC_I: nxt = ALUWB;
         ALUWB, BRANCH:  nxt = FETCH;
         TRAP:   nxt = TRAP;
         default: nxt = TRAP;
      endcase
   end

   // Outputs are decoded from the next state so they are registered alongside it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         req_q   <= 1'b0; we_q  <= 1'b0; adr_q <= 1'b0; rw_q <= 1'b0;
         ret_q   <= 1'b0; ill_q <= 1'b0;
         fetch_q <= 1'b0; memwr_q <= 1'b0; beq_q <= 1'b0; bne_q <= 1'b0;
         imm_q   <= 2'b00; a_q <= 2'b00; b_q <= 2'b00; op_q <= 2'b00; rs_q <= 2'b00;
      end else begin
         state <= nxt;
         cnt   <= (req_q && !bus.mem_ready) ? cnt + CW'(1) : '0;

         req_q   <= 1'b0; we_q  <= 1'b0; adr_q <= 1'b0; rw_q <= 1'b0;
         ret_q   <= 1'b0; ill_q <= 1'b0;
         fetch_q <= 1'b0; memwr_q <= 1'b0; beq_q <= 1'b0; bne_q <= 1'b0;
         imm_q   <= 2'b00; a_q <= 2'b00; b_q <= 2'b00; op_q <= 2'b00; rs_q <= 2'b00;

         case (nxt)
            FETCH:  begin req_q <= 1'b1; fetch_q <= 1'b1; b_q <= 2'b10; rs_q <= 2'b10; end
            DECODE: begin a_q <= 2'b01; b_q <= 2'b01; imm_q <= 2'b10; end
            MEMADR: begin a_q <= 2'b10; b_q <= 2'b01; imm_q <= is_store ? 2'b01 : 2'b00; end
            MEMRD:  begin req_q <= 1'b1; adr_q <= 1'b1; end
            MEMWB:  begin rw_q <= 1'b1; rs_q <= 2'b01; ret_q <= 1'b1; end
            MEMWR:  begin req_q <= 1'b1; we_q <= 1'b1; adr_q <= 1'b1; memwr_q <= 1'b1; end
            EXEC_R: begin a_q <= 2'b10; op_q <= 2'b10; end
            EXEC_I: begin a_q <= 2'b10; b_q <= 2'b01; op_q <= 2'b10; end
            ALUWB:  begin rw_q <= 1'b1; ret_q <= 1'b1; end
            BRANCH: begin
               a_q   <= 2'b10;
               op_q  <= 2'b01;
               ret_q <= 1'b1;
               beq_q <= (funct3 == 3'b000);
               bne_q <= (funct3 == 3'b001);
            end
            TRAP:   ill_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.mem_req    = req_q;
   assign bus.mem_we     = we_q;
   assign bus.adr_src    = adr_q;
   assign bus.reg_write  = rw_q;
   assign bus.imm_src    = imm_q;
   assign bus.alu_src_a  = a_q;
   assign bus.alu_src_b  = b_q;
   assign bus.alu_op     = op_q;
   assign bus.result_src = rs_q;
   assign bus.illegal    = ill_q;
   // completion-qualified strobes fire in the same cycle the handshake or flag arrives
   assign bus.ir_write   = fetch_q & bus.mem_ready;
   assign bus.pc_write   = (fetch_q & bus.mem_ready) | (beq_q & bus.zero) | (bne_q & ~bus.zero);
   assign bus.retire     = ret_q | (memwr_q & bus.mem_ready);
endmodule
